// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier: operand width, iteration
// count, counter width and the control FSM state encoding.
package mult_pkg;

    localparam int MULT_WIDTH = 32;
    localparam int MULT_ITER  = 32;
    localparam int CNT_W      = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/booth_step.sv
// One multiply iteration, purely combinational.
// cur/nxt pack {upper, lower, q(-1)} into 65 bits.
// In signed mode the step is radix-2 Booth. In unsigned mode it is a plain shift-add.
module booth_step
    import mult_pkg::*;
(
    input  logic [2*MULT_WIDTH:0]   cur,
    input  logic [MULT_WIDTH-1:0]   mcand,
    input  logic                    unsigned_mode,
    output logic [2*MULT_WIDTH:0]   nxt
);

    logic [MULT_WIDTH-1:0] upper;
    logic [MULT_WIDTH-1:0] lower;
    logic                  q;
    logic [MULT_WIDTH:0]   up_ext;
    logic [MULT_WIDTH:0]   mc_ext;
    logic [MULT_WIDTH:0]   sum;

    // Add/subtract into a 33-bit upper half, then shift the whole word right by one.
    // Bit 32 of the sum keeps the true sign (signed mode) or the carry (unsigned mode).
    // That makes {sum, lower} exactly the shifted 65-bit result.
    // The lower LSB drops out into the q(-1) position.
    always_comb begin
        upper  = cur[2*MULT_WIDTH:MULT_WIDTH+1];
        lower  = cur[MULT_WIDTH:1];
        q      = cur[0];
        up_ext = '0;
        mc_ext = '0;
        sum    = '0;
        if (unsigned_mode) begin
            up_ext = {1'b0, upper};
            mc_ext = {1'b0, mcand};
            sum    = lower[0] ? (up_ext + mc_ext) : up_ext;
        end else begin
            up_ext = {upper[MULT_WIDTH-1], upper};
            mc_ext = {mcand[MULT_WIDTH-1], mcand};
            case ({lower[0], q})
                2'b10:   sum = up_ext - mc_ext;
                2'b01:   sum = up_ext + mc_ext;
                default: sum = up_ext;
            endcase
        end
        nxt = {sum, lower};
    end

endmodule

// File: rtl/mult_sequencer.sv
// Sequential 32x32 -> 64 multiplier: one iteration per clock, 32 iterations,
// then a one-cycle done pulse with the product on hi/lo.
// Optional unsigned (MULTU) support is enabled by defining MULT_SEQ_MULTU_EN.
module mult_sequencer
    import mult_pkg::*;
(
    input  logic                    Clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [MULT_WIDTH-1:0]   oper_A,
    input  logic [MULT_WIDTH-1:0]   oper_B,
`ifdef MULT_SEQ_MULTU_EN
    input  logic                    mult_unsigned,
`endif
    output logic                    busy,
    output logic                    done,
    output logic                    HiLo_load,
    output logic [MULT_WIDTH-1:0]   hi,
    output logic [MULT_WIDTH-1:0]   lo,
    output logic [CNT_W-1:0]        MultCounter
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MULT_ITER - 1);

    state_t                  state_reg;
    logic [2*MULT_WIDTH:0]   prod_reg;
    logic [2*MULT_WIDTH:0]   prod_next;
    logic [MULT_WIDTH-1:0]   mcand_reg;
    logic                    step_unsigned;

`ifdef MULT_SEQ_MULTU_EN
    logic unsigned_reg;

    // Latch the signed/unsigned mode with the operands so later changes cannot affect it.
    always_ff @(posedge Clk) begin
        if (reset)
            unsigned_reg <= 1'b0;
        else if (state_reg == IDLE && start)
            unsigned_reg <= mult_unsigned;
    end

    assign step_unsigned = unsigned_reg;
`else
    assign step_unsigned = 1'b0;
`endif

    booth_step u_step (
        .cur           (prod_reg),
        .mcand         (mcand_reg),
        .unsigned_mode (step_unsigned),
        .nxt           (prod_next)
    );

    // HI/LO load enables follow the done pulse exactly.
    assign HiLo_load = done;

    // Control FSM, iteration counter, working registers and result registers.
    // The multiplier sits in the lower half of the working word.
    // Its bits are consumed as the word shifts right.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            prod_reg    <= '0;
            mcand_reg   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            MultCounter <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_reg   <= RUN;
                        busy        <= 1'b1;
                        mcand_reg   <= oper_A;
                        prod_reg    <= {{MULT_WIDTH{1'b0}}, oper_B, 1'b0};
                        MultCounter <= '0;
                    end
                end
                RUN: begin
                    prod_reg <= prod_next;
                    if (MultCounter == LAST_ITER) begin
                        state_reg   <= DONE;
                        done        <= 1'b1;
                        hi          <= prod_next[2*MULT_WIDTH:MULT_WIDTH+1];
                        lo          <= prod_next[MULT_WIDTH:1];
                        MultCounter <= '0;
                    end else begin
                        MultCounter <= MultCounter + 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
                default: begin
                    state_reg   <= IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    MultCounter <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed self-checking bench for mult_sequencer.
// The MULTU cases are compiled in when MULT_SEQ_MULTU_EN is defined.
module tb_mult_sequencer;

    logic        Clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] oper_A;
    logic [31:0] oper_B;
`ifdef MULT_SEQ_MULTU_EN
    logic        mult_unsigned;
`endif
    logic        busy;
    logic        done;
    logic        HiLo_load;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [5:0]  MultCounter;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] res;
    int          lat;
    int          bcnt;
    int          k;
    int          dones;
    int          first_d;
    int          second_d;
    logic [31:0] lo_cap;
    logic [31:0] hi_cap;

    always #5 Clk = ~Clk;

    mult_sequencer dut (
        .Clk         (Clk),
        .reset       (reset),
        .start       (start),
        .oper_A      (oper_A),
        .oper_B      (oper_B),
`ifdef MULT_SEQ_MULTU_EN
        .mult_unsigned (mult_unsigned),
`endif
        .busy        (busy),
        .done        (done),
        .HiLo_load   (HiLo_load),
        .hi          (hi),
        .lo          (lo),
        .MultCounter (MultCounter)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Issue one multiply and wait for done.
    // latency counts cycles after the start-sampling edge; busy_cycles counts cycles with busy high.
    task automatic mul(input logic [31:0] a, input logic [31:0] b, input bit scramble,
                       output logic [63:0] r, output int latency, output int busy_cycles);
        int n;
        @(negedge Clk);
        start  = 1'b1;
        oper_A = a;
        oper_B = b;
        @(negedge Clk);
        start = 1'b0;
        n = 1;
        busy_cycles = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && n < 100) begin
            if (scramble) begin
                oper_A = $urandom;
                oper_B = $urandom;
            end
            @(negedge Clk);
            n++;
            if (busy === 1'b1) busy_cycles++;
        end
        latency = n;
        r = {hi, lo};
        chk("hilo_load_at_done", 64'(HiLo_load), 64'd1);
        $display("mul a=0x%h b=0x%h -> hi=0x%h lo=0x%h latency=%0d", a, b, hi, lo, n);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        oper_A = '0;
        oper_B = '0;
`ifdef MULT_SEQ_MULTU_EN
        mult_unsigned = 1'b0;
`endif
        // Reset dominates a simultaneous start.
        @(negedge Clk);
        start = 1'b1;
        repeat (2) @(negedge Clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_hilo_load", 64'(HiLo_load), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        chk("reset_counter", 64'(MultCounter), 64'd0);
        start = 1'b0;
        reset = 1'b0;

        // Basic signed multiply, latency and busy width.
        mul(32'd7, 32'd6, 1'b0, res, lat, bcnt);
        chk("7x6_product", res, 64'h0000_0000_0000_002A);
        chk("7x6_latency", 64'(lat), 64'd33);
        chk("7x6_busy_cycles", 64'(bcnt), 64'd33);
        @(negedge Clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("busy_low_after", 64'(busy), 64'd0);
        chk("hilo_hold", {hi, lo}, 64'h0000_0000_0000_002A);

        // Sign cases.
        mul(32'hFFFF_FFFF, 32'h0000_0002, 1'b0, res, lat, bcnt);
        chk("neg1x2_product", res, 64'hFFFF_FFFF_FFFF_FFFE);
        mul(32'h8000_0000, 32'h8000_0000, 1'b0, res, lat, bcnt);
        chk("minxmin_product", res, 64'h4000_0000_0000_0000);

`ifdef MULT_SEQ_MULTU_EN
        mult_unsigned = 1'b1;
        mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, res, lat, bcnt);
        chk("multu_max_product", res, 64'hFFFF_FFFE_0000_0001);
        chk("multu_latency", 64'(lat), 64'd33);
        mult_unsigned = 1'b0;
        mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, res, lat, bcnt);
        chk("mult_neg1xneg1", res, 64'h0000_0000_0000_0001);
`endif

        // Operands scrambled every cycle after acceptance: 0x12345678 * -13.
        mul(32'h1234_5678, 32'hFFFF_FFF3, 1'b1, res, lat, bcnt);
        chk("stable_operands_product", res, 64'hFFFF_FFFF_1357_9BE8);

        // Start during busy must be ignored: 3*5 with a 9*9 request at MultCounter=20.
        @(negedge Clk);
        start  = 1'b1;
        oper_A = 32'd3;
        oper_B = 32'd5;
        @(negedge Clk);
        start = 1'b0;
        k = 0;
        while (MultCounter !== 6'd20 && k < 100) begin
            @(negedge Clk);
            k++;
        end
        chk("reach_counter_20", 64'(MultCounter), 64'd20);
        start  = 1'b1;
        oper_A = 32'd9;
        oper_B = 32'd9;
        @(negedge Clk);
        start = 1'b0;
        dones  = 0;
        lo_cap = '1;
        hi_cap = '1;
        for (int i = 0; i < 80; i++) begin
            @(negedge Clk);
            if (done === 1'b1) begin
                dones++;
                lo_cap = lo;
                hi_cap = hi;
            end
        end
        $display("busy-start test: dones=%0d hi=0x%h lo=0x%h", dones, hi_cap, lo_cap);
        chk("busy_start_done_count", 64'(dones), 64'd1);
        chk("busy_start_lo", 64'(lo_cap), 64'h0000_000F);
        chk("busy_start_hi", 64'(hi_cap), 64'h0000_0000);

        // Reset at MultCounter=10 aborts the operation.
        @(negedge Clk);
        start  = 1'b1;
        oper_A = 32'h0000_1234;
        oper_B = 32'h0000_0010;
        @(negedge Clk);
        start = 1'b0;
        k = 0;
        while (MultCounter !== 6'd10 && k < 100) begin
            @(negedge Clk);
            k++;
        end
        chk("reach_counter_10", 64'(MultCounter), 64'd10);
        reset = 1'b1;
        @(negedge Clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        chk("abort_counter", 64'(MultCounter), 64'd0);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (done === 1'b1) dones++;
        end
        $display("reset-abort test: dones in 40 cycles=%0d", dones);
        chk("abort_no_done", 64'(dones), 64'd0);
        mul(32'd3, 32'd5, 1'b0, res, lat, bcnt);
        chk("after_reset_product", res, 64'h0000_0000_0000_000F);
        chk("after_reset_latency", 64'(lat), 64'd33);

        // Start held high: back-to-back operations with one IDLE cycle between.
        @(negedge Clk);
        start    = 1'b1;
        oper_A   = 32'd2;
        oper_B   = 32'd3;
        k        = 0;
        first_d  = 0;
        second_d = 0;
        while (second_d == 0 && k < 150) begin
            @(negedge Clk);
            k++;
            if (done === 1'b1) begin
                if (first_d == 0) first_d = k;
                else second_d = k;
            end
        end
        start = 1'b0;
        $display("back-to-back: first done=%0d second done=%0d lo=0x%h", first_d, second_d, lo);
        chk("b2b_first_done", 64'(first_d), 64'd33);
        chk("b2b_second_done", 64'(second_d), 64'd67);
        chk("b2b_product", {hi, lo}, 64'h0000_0000_0000_0006);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 oper_A  input  32  multiplicand; captured on the accepted start.
REQ-006 oper_B  input  32  multiplier; captured on the accepted start.
REQ-007 busy  output  1  high in RUN and DONE.
REQ-008 done  output  1  one-cycle pulse; hi/lo hold the new result in that cycle.
REQ-009 HiLo_load  output  1  equals done; drives the HI/LO register load enables.
REQ-010 hi  output  32  upper product word.
REQ-011 lo  output  32  lower product word.
REQ-012 MultCounter  output  6  iteration index; 0 in IDLE and DONE, 0..31 in RUN.

Function
REQ-013 The FSM SHALL have three states, IDLE, RUN and DONE, with transitions as follows.
- IDLE->RUN on start=1.
- RUN->DONE after the iteration where MultCounter=31.
- DONE->IDLE unconditionally.
REQ-014 On an accepted start, the block SHALL latch oper_A and oper_B, clear the 64-bit accumulator and the Booth bit q(-1), and set MultCounter=0.
REQ-015 The signed (default) algorithm SHALL be radix-2 Booth with one iteration per RUN cycle.
- Examine {acc[0], q(-1)}: pair 10 subtracts the multiplicand from the upper half; pair 01 adds it.
- Then arithmetic-shift the 65-bit {upper, lower, q(-1)} right by one.
REQ-016 Upper-half add and subtract SHALL use 33-bit arithmetic so that no intermediate overflow corrupts the sign bit.
REQ-017 Exactly 32 RUN cycles SHALL occur, and done SHALL assert in the 33rd cycle after the cycle in which start was sampled high.
REQ-018 hi and lo SHALL update only in the cycle that enters DONE and SHALL hold otherwise.
REQ-019 start asserted in RUN or DONE SHALL be ignored: no queueing and no restart.
REQ-020 start held high continuously SHALL produce back-to-back operations, with one IDLE cycle between done and the next acceptance.
REQ-021 oper_A and oper_B changing after acceptance SHALL NOT affect the result.
REQ-022 The result SHALL be the full 64-bit product, with no truncation and no overflow flag.

Reset
REQ-023 While reset=1, the block SHALL force the following values, taking priority over start in the same cycle:
- state=IDLE
- busy=0, done=0, HiLo_load=0
- hi=0, lo=0, MultCounter=0
- internal accumulator and q(-1) = 0
REQ-024 Reset during RUN SHALL abort the operation, with no done pulse and hi/lo cleared.
REQ-025 The first start after reset deasserts SHALL be accepted normally.

Configuration
REQ-026 The macro MULT_SEQ_MULTU_EN SHALL control unsigned-multiply (MULTU) support.
REQ-027 With MULT_SEQ_MULTU_EN defined:
- The block SHALL add input mult_unsigned (1 bit), latched on the accepted start.
- When mult_unsigned=1, each iteration SHALL be a plain shift-add: add the multiplicand if acc[0]=1, keep the carry in bit 32, then shift right logically.
- Latency SHALL be the same 32 iterations.
REQ-028 Without MULT_SEQ_MULTU_EN, the mult_unsigned port SHALL be absent and all operations SHALL be signed Booth.

Structure
REQ-029 Shared package mult_pkg SHALL hold:
- the state enum (IDLE, RUN, DONE)
- MULT_WIDTH=32
- MULT_ITER=32
- the counter width, 6
REQ-030 The block SHALL contain one combinational sub-module, booth_step, that computes one iteration: {upper, lower, q(-1)} and mode in, next value out.
REQ-031 The FSM, the counter and the hi/lo registers SHALL stay in mult_sequencer.

Verification
REQ-032 Basic signed: 7*6 -> hi=0x00000000, lo=0x0000002A; done exactly 33 cycles after start; busy high for 33 cycles.
REQ-033 Sign cases:
- 0xFFFFFFFF*0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- 0x80000000*0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-034 MULTU (macro defined): 0xFFFFFFFF*0xFFFFFFFF with mult_unsigned=1 -> hi=0xFFFFFFFE, lo=0x00000001; the same operands with mult_unsigned=0 -> hi=0, lo=1.
REQ-035 Reset mid-operation: reset at MultCounter=10 -> next cycle state IDLE, busy=0, hi=lo=0, and no done pulse in the following 40 cycles.
REQ-036 Start during busy: run 3*5, pulse start with 9*9 at MultCounter=20 -> single done with lo=0x0000000F and no second done.
REQ-037 Operand stability: change oper_A and oper_B every cycle after acceptance -> result matches the operands captured at acceptance.
